// File: rtl/mc_ctrl_fsm.sv
// Main control FSM for the multicycle MIPS core.
// Sequences ALU, register file, memory port and PC/IR/ALUOut/MDR.
module mc_ctrl_fsm #(
    parameter int unsigned MEM_WAIT_MAX = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_sel,
    output logic [1:0] alu_a_sel,
    output logic [2:0] alu_b_sel,
    output logic [3:0] aluinst,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_RST = 3'd0,
        S_IF  = 3'd1,
        S_ID  = 3'd2,
        S_EX  = 3'd3,
        S_MEM = 3'd4,
        S_WB  = 3'd5
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LU   = 4'd11;
    localparam logic [3:0] ALU_BNE  = 4'd12;
    localparam logic [3:0] ALU_BLEZ = 4'd13;
    localparam logic [3:0] ALU_BGTZ = 4'd14;
    localparam logic [3:0] ALU_BLTZ = 4'd15;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_wait;
    logic        w_timeout;

    logic       w_rtype;
    logic       w_jr;
    logic       w_shift_imm;
    logic       w_r_ok;
    logic       w_ialu;
    logic       w_lw;
    logic       w_sw;
    logic       w_br;
    logic       w_j;
    logic       w_jal;
    logic       w_legal;
    logic [3:0] w_r_alu;
    logic [3:0] w_i_alu;
    logic [3:0] w_b_alu;
    logic [2:0] w_i_bsel;

    assign w_rtype     = (opcode == 6'h00);
    assign w_jr        = w_rtype && (funct == 6'h08);
    assign w_shift_imm = w_rtype && ((funct == 6'h00) ||
                                     (funct == 6'h02) ||
                                     (funct == 6'h03));
    assign w_ialu      = (opcode[5:3] == 3'b001);
    assign w_lw        = (opcode == 6'h23);
    assign w_sw        = (opcode == 6'h2B);
    assign w_br        = (opcode == 6'h01) || (opcode[5:2] == 4'b0001);
    assign w_j         = (opcode == 6'h02);
    assign w_jal       = (opcode == 6'h03);
    assign w_legal     = (w_rtype && w_r_ok) || w_ialu || w_lw || w_sw ||
                         w_br || w_j || w_jal;

    assign w_timeout = (MEM_WAIT_MAX != 0) &&
                       ((r_state == S_IF) || (r_state == S_MEM)) &&
                       !mem_ready && (r_wait >= MEM_WAIT_MAX);

    assign state_dbg = r_state;

    // R-type funct to ALU operation; flags undecodable functs
    always_comb begin
        w_r_ok  = 1'b1;
        w_r_alu = ALU_ADD;
        unique case (funct)
            6'h20, 6'h21: w_r_alu = ALU_ADD;
            6'h22, 6'h23: w_r_alu = ALU_SUB;
            6'h24:        w_r_alu = ALU_AND;
            6'h25:        w_r_alu = ALU_OR;
            6'h26:        w_r_alu = ALU_XOR;
            6'h27:        w_r_alu = ALU_NOR;
            6'h2A:        w_r_alu = ALU_SLT;
            6'h2B:        w_r_alu = ALU_SLTU;
            6'h00, 6'h04: w_r_alu = ALU_SLL;
            6'h02, 6'h06: w_r_alu = ALU_SRL;
            6'h03, 6'h07: w_r_alu = ALU_SRA;
            6'h08:        w_r_alu = ALU_ADD;
            default:      w_r_ok  = 1'b0;
        endcase
    end

    // I-type ALU and branch opcode to ALU operation / B operand
    always_comb begin
        w_i_alu  = ALU_ADD;
        w_i_bsel = 3'd2;
        w_b_alu  = ALU_SUB;
        unique case (opcode)
            6'h0A: w_i_alu = ALU_SLT;
            6'h0B: w_i_alu = ALU_SLTU;
            6'h0C: begin w_i_alu = ALU_AND; w_i_bsel = 3'd3; end
            6'h0D: begin w_i_alu = ALU_OR;  w_i_bsel = 3'd3; end
            6'h0E: begin w_i_alu = ALU_XOR; w_i_bsel = 3'd3; end
            6'h0F: begin w_i_alu = ALU_LU;  w_i_bsel = 3'd3; end
            6'h05: w_b_alu = ALU_BNE;
            6'h06: w_b_alu = ALU_BLEZ;
            6'h07: w_b_alu = ALU_BGTZ;
            6'h01: w_b_alu = ALU_BLTZ;
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RST;
        else        r_state <= w_next;
    end

    // Memory wait counter: cleared on any state change or timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= '0;
        end else if (w_timeout || (w_next != r_state)) begin
            r_wait <= '0;
        end else if (!mem_ready && (r_wait != '1) &&
                     ((r_state == S_IF) || (r_state == S_MEM))) begin
            r_wait <= r_wait + 32'd1;
        end
    end

    // Next-state and control outputs
    always_comb begin
        w_next     = r_state;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'd0;
        wb_sel     = 2'd0;
        alu_a_sel  = 2'd0;
        alu_b_sel  = 3'd0;
        aluinst    = ALU_ADD;
        illegal_op = 1'b0;
        mem_err    = 1'b0;
        unique case (r_state)
            S_RST: w_next = S_IF;
            S_IF: begin
                if (w_timeout) begin
                    mem_err = 1'b1;
                    w_next  = S_IF;
                end else begin
                    mem_read  = 1'b1;
                    alu_b_sel = 3'd1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        w_next   = S_ID;
                    end
                end
            end
            S_ID: begin
                alu_b_sel = 3'd4;
                w_next    = S_EX;
                unique case (1'b1)
                    !w_legal: begin
                        illegal_op = 1'b1;
                        w_next     = S_IF;
                    end
                    w_j: begin
                        pc_write = 1'b1;
                        pc_src   = 2'd2;
                        w_next   = S_IF;
                    end
                    w_jal: begin
                        pc_write  = 1'b1;
                        pc_src    = 2'd2;
                        reg_write = 1'b1;
                        reg_dst   = 2'd2;
                        wb_sel    = 2'd2;
                        w_next    = S_IF;
                    end
                    w_jr: begin
                        pc_write = 1'b1;
                        pc_src   = 2'd3;
                        w_next   = S_IF;
                    end
                    default: ;
                endcase
            end
            S_EX: begin
                alu_a_sel = 2'd1;
                w_next    = S_IF;
                unique case (1'b1)
                    w_rtype: begin
                        if (w_shift_imm) alu_a_sel = 2'd2;
                        aluinst = w_r_alu;
                        w_next  = S_WB;
                    end
                    w_ialu: begin
                        alu_b_sel = w_i_bsel;
                        aluinst   = w_i_alu;
                        w_next    = S_WB;
                    end
                    (w_lw || w_sw): begin
                        alu_b_sel = 3'd2;
                        w_next    = S_MEM;
                    end
                    w_br: begin
                        aluinst  = w_b_alu;
                        pc_src   = 2'd1;
                        pc_write = zero;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (w_timeout) begin
                    mem_err = 1'b1;
                    w_next  = S_IF;
                end else begin
                    i_or_d    = 1'b1;
                    mem_read  = w_lw;
                    mem_write = w_sw;
                    if (mem_ready) w_next = w_lw ? S_WB : S_IF;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                reg_dst   = w_rtype ? 2'd1 : 2'd0;
                wb_sel    = w_lw ? 2'd1 : 2'd0;
                w_next    = S_IF;
            end
            default: w_next = S_IF;
        endcase
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Main control FSM for the multicycle MIPS core; sequences the shared ALU, register file, memory port and PC/IR/ALUOut/MDR registers.
- Decodes latched IR opcode/funct and drives ALU operand selects and `aluinst` codes from alu_define.v.
- Branch decision rule is uniform: taken iff ALU `Zero` = 1 during EX.

Parameters:
- MEM_WAIT_MAX, 0, maximum wait cycles for mem_ready in IF/MEM; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU Zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  PC load enable
- pc_src  out  2  PC source: 0=ALU result, 1=ALUOut, 2=jump target, 3=rs
- ir_write  out  1  IR load enable
- mem_read  out  1  memory read
- mem_write  out  1  memory write
- i_or_d  out  1  address select: 0=PC, 1=ALUOut
- reg_write  out  1  register-file write
- reg_dst  out  2  write register: 0=rt, 1=rd, 2=$31
- wb_sel  out  2  write data: 0=ALUOut, 1=MDR, 2=PC
- alu_a_sel  out  2  ALU A: 0=PC, 1=rs, 2=zero-extended shamt
- alu_b_sel  out  3  ALU B: 0=rt, 1=const 4, 2=sign-extended imm, 3=zero-extended imm, 4=sign-extended imm<<2
- aluinst  out  4  ALU operation code
- illegal_op  out  1  one-cycle pulse on an undecodable instruction
- mem_err  out  1  one-cycle pulse on memory timeout
- state_dbg  out  3  current state

Behaviour:
- States: RST=0, IF=1, ID=2, EX=3, MEM=4, WB=5. State is registered; outputs are combinational from state plus opcode/funct.
- Reset: rst_n low forces RST asynchronously. In RST every output is 0 and state_dbg=0. The first edge after release moves to IF.
- Outputs not listed for a state are 0.
- IF:
  - Asserts mem_read, i_or_d=0, ir_write, alu_a_sel=0, alu_b_sel=1, aluinst=ADD, pc_src=0, pc_write.
  - ir_write and pc_write are asserted only when mem_ready=1; that edge moves to ID. Otherwise stay in IF.
- ID:
  - alu_a_sel=0, alu_b_sel=4, aluinst=ADD: branch target is written to ALUOut.
  - J: pc_write, pc_src=2, then IF.
  - JAL: as J plus reg_write, reg_dst=2, wb_sel=2. PC still holds PC+4 on this edge.
  - R-type funct 0x08 (JR): pc_write, pc_src=3, then IF.
  - Undecodable opcode or R-type funct: illegal_op=1, then IF.
  - All others go to EX.
- EX, R-type:
  - Operands: A=rs, B=rt. For SLL/SRL/SRA (funct 00/02/03), A=shamt.
  - funct mapping: 20/21→ADD, 22/23→SUB, 24→AND, 25→OR, 26→XOR, 27→NOR, 2A→SLT, 2B→SLTU, 00/04→SLL, 02/06→SRL, 03/07→SRA.
  - Next state: WB.
- EX, I-type ALU:
  - ADDI/ADDIU(08/09)→ADD, sign-extended imm.
  - SLTI(0A)→SLT, SLTIU(0B)→SLTU, sign-extended imm.
  - ANDI/ORI/XORI(0C/0D/0E), zero-extended imm.
  - LUI(0F)→LU.
  - A=rs. Next state: WB.
- EX, LW(23)/SW(2B): A=rs, B=sign-extended imm, ADD; next state MEM.
- EX, branches:
  - Operands: A=rs, B=rt.
  - BEQ(04)→SUB, BNE(05)→BNE, BLEZ(06)→BLEZ, BGTZ(07)→BGTZ, REGIMM(01)→BLTZ.
  - pc_src=1; pc_write=zero.
  - Next state: IF.
- MEM:
  - Asserts i_or_d=1.
  - LW asserts mem_read; SW asserts mem_write.
  - On mem_ready: LW goes to WB, SW goes to IF.
- WB:
  - reg_write=1.
  - R-type: reg_dst=1, wb_sel=0.
  - I-ALU: reg_dst=0, wb_sel=0.
  - LW: reg_dst=0, wb_sel=1.
  - Next state: IF.
- Timeout:
  - A wait counter clears on entry to IF/MEM and increments on each cycle with mem_ready=0.
  - If MEM_WAIT_MAX≠0 and the counter reaches MEM_WAIT_MAX: pulse mem_err for one cycle, deassert strobes, go to IF. PC, IR and registers are unchanged.
- Cycle counts with mem_ready held at 1: J/JAL/JR=2, branch=3, R/I-ALU=4, SW=4, LW=5.
- Reset asserted mid-instruction: abort immediately; no partial write enables remain asserted.

Test Plan:
- Reset: hold rst_n=0 then release → all outputs 0, state_dbg=0; first edge → IF; IF with mem_ready=1 asserts pc_write and ir_write.
- ADD (op 00, funct 20), mem_ready=1 → states 1,2,3,5,1; EX aluinst=ADD, alu_a_sel=1, alu_b_sel=0; WB reg_write=1, reg_dst=1.
- LW (op 23), mem_ready low 3 cycles in MEM, MEM_WAIT_MAX=0 → MEM held 4 cycles with mem_read=1, i_or_d=1; then WB wb_sel=1; no mem_err.
- BNE (op 05): zero=1 in EX → pc_write=1, pc_src=1; repeat with zero=0 → pc_write=0; both cases next state IF.
- JAL (op 03) → ID asserts pc_write, pc_src=2, reg_write, reg_dst=2, wb_sel=2; next state IF.
- Opcode 0x3F → illegal_op pulses 1 cycle in ID, next state IF. MEM_WAIT_MAX=2 with mem_ready=0 in IF → mem_err pulses once, state stays IF, no pc_write.
